// File: rtl/fios_host_loader.sv
`default_nettype none
// ============================================================================
// Module   : fios_host_loader
// Purpose  : Host-side front end for the FIOS cascade controller. Streams
//            3*S+1 operand words into the shared BRAM, pulses the controller
//            start, waits for done, then reads the S result words back out
//            through a 4-entry FIFO as a flow-controlled output stream.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clock_i, reset_i        clock, synchronous active-low reset
//   in_valid_i/in_ready_o   operand word handshake, data on in_data_i
//   out_valid_o/out_ready_i result word handshake, data on out_data_o,
//                           out_last_o marks result word S-1
//   BRAM_*                  host-side BRAM port (en/we/addr/din/dout)
//   top_reset_o             active-high controller reset (high in IDLE)
//   top_start_o             one-cycle controller start pulse
//   top_done_i              controller done level (only sampled in WAIT)
//   busy_o                  high in every state except IDLE
// ============================================================================
module fios_host_loader #(
    parameter  int S      = 8,
    parameter  int W      = 17,
    parameter  int RD_LAT = 2,
    localparam int AW     = $clog2(4 * S)
) (
    input  logic          clock_i,
    input  logic          reset_i,
    input  logic          in_valid_i,
    output logic          in_ready_o,
    input  logic [W-1:0]  in_data_i,
    output logic          out_valid_o,
    input  logic          out_ready_i,
    output logic [W-1:0]  out_data_o,
    output logic          out_last_o,
    output logic          BRAM_en_o,
    output logic          BRAM_we_o,
    output logic [AW-1:0] BRAM_addr_o,
    output logic [W-1:0]  BRAM_din_o,
    input  logic [W-1:0]  BRAM_dout_i,
    output logic          top_reset_o,
    output logic          top_start_o,
    input  logic          top_done_i,
    output logic          busy_o
);

    localparam int            IW         = $clog2(S + 1);
    localparam logic [AW-1:0] LAST_WADDR = AW'(3 * S);
    localparam logic [IW-1:0] NUM_RES    = IW'(S);
    localparam logic [IW-1:0] LAST_RES   = IW'(S - 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_START = 3'd2,
        ST_WAIT  = 3'd3,
        ST_READ  = 3'd4
    } state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   wcnt_q, wcnt_d;     // next operand write address
    logic [IW-1:0]   icnt_q, icnt_d;     // next result read to issue
    logic [RD_LAT-1:0] vpipe_q;          // read-in-flight markers per stage
    logic [RD_LAT-1:0] lpipe_q;          // "last result" flag riding along
    logic [W:0]      fifo_q [4];         // {last, data}
    logic [1:0]      wptr_q, rptr_q;
    logic [2:0]      cnt_q;

    logic [2:0]      w_inflight;
    logic            w_nempty;
    logic            w_issue;
    logic            w_pop;
    logic            w_push;

    // Reads still travelling through the BRAM pipeline
    always_comb begin
        w_inflight = '0;
        for (int k = 0; k < RD_LAT; k++) begin
            w_inflight = w_inflight + {2'b00, vpipe_q[k]};
        end
    end

    assign w_push   = vpipe_q[RD_LAT-1];
    assign w_nempty = (cnt_q != 3'd0);

    // Next state and outputs. While reset_i is low every output is forced
    // to its idle value (only top_reset_o high) so nothing is handshaken.
    always_comb begin
        state_d     = state_q;
        wcnt_d      = wcnt_q;
        icnt_d      = icnt_q;
        in_ready_o  = 1'b0;
        out_valid_o = 1'b0;
        out_data_o  = '0;
        out_last_o  = 1'b0;
        BRAM_en_o   = 1'b0;
        BRAM_we_o   = 1'b0;
        BRAM_addr_o = '0;
        BRAM_din_o  = '0;
        top_reset_o = 1'b1;
        top_start_o = 1'b0;
        busy_o      = 1'b0;
        w_issue     = 1'b0;
        w_pop       = 1'b0;

        if (reset_i) begin
            top_reset_o = (state_q == ST_IDLE);
            busy_o      = (state_q != ST_IDLE);
            case (state_q)
                ST_IDLE: begin
                    in_ready_o = 1'b1;
                    if (in_valid_i) begin
                        BRAM_en_o  = 1'b1;
                        BRAM_we_o  = 1'b1;
                        BRAM_din_o = in_data_i;
                        wcnt_d     = AW'(1);
                        state_d    = ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    in_ready_o = 1'b1;
                    if (in_valid_i) begin
                        BRAM_en_o   = 1'b1;
                        BRAM_we_o   = 1'b1;
                        BRAM_addr_o = wcnt_q;
                        BRAM_din_o  = in_data_i;
                        // Counter parks at 3S; IDLE reloads it on the next job
                        if (wcnt_q == LAST_WADDR) begin
                            state_d = ST_START;
                        end else begin
                            wcnt_d = wcnt_q + AW'(1);
                        end
                    end
                end
                ST_START: begin
                    top_start_o = 1'b1;
                    state_d     = ST_WAIT;
                end
                ST_WAIT: begin
                    if (top_done_i) begin
                        icnt_d  = '0;
                        state_d = ST_READ;
                    end
                end
                ST_READ: begin
                    out_valid_o = w_nempty;
                    if (w_nempty) begin
                        out_data_o = fifo_q[rptr_q][W-1:0];
                        out_last_o = fifo_q[rptr_q][W];
                    end
                    w_pop = w_nempty && out_ready_i;
                    // Credit check: FIFO entries plus reads in flight never
                    // exceed the FIFO depth, so a capture always has a slot.
                    if ((icnt_q < NUM_RES) &&
                        (({1'b0, cnt_q} + {1'b0, w_inflight}) < 4'd4)) begin
                        w_issue     = 1'b1;
                        BRAM_en_o   = 1'b1;
                        BRAM_addr_o = AW'(icnt_q);
                        icnt_d      = icnt_q + IW'(1);
                    end
                    if (w_pop && fifo_q[rptr_q][W]) begin
                        state_d = ST_IDLE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clock_i) begin
        if (!reset_i) begin
            state_q <= ST_IDLE;
            wcnt_q  <= '0;
            icnt_q  <= '0;
            vpipe_q <= '0;
            lpipe_q <= '0;
            wptr_q  <= '0;
            rptr_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q    <= state_d;
            wcnt_q     <= wcnt_d;
            icnt_q     <= icnt_d;
            vpipe_q[0] <= w_issue;
            lpipe_q[0] <= w_issue && (icnt_q == LAST_RES);
            for (int k = 1; k < RD_LAT; k++) begin
                vpipe_q[k] <= vpipe_q[k-1];
                lpipe_q[k] <= lpipe_q[k-1];
            end
            if (w_push) begin
                wptr_q <= wptr_q + 2'd1;
            end
            if (w_pop) begin
                rptr_q <= rptr_q + 2'd1;
            end
            case ({w_push, w_pop})
                2'b10:   cnt_q <= cnt_q + 3'd1;
                2'b01:   cnt_q <= cnt_q - 3'd1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    // FIFO storage needs no reset; occupancy and pointers qualify it
    always_ff @(posedge clock_i) begin
        if (reset_i && w_push) begin
            fifo_q[wptr_q] <= {lpipe_q[RD_LAT-1], BRAM_dout_i};
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fios_host_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_fios_host_loader
// Purpose  : Self-checking bench for fios_host_loader. Load phases are driven
//            from a per-cycle vector table; the wait, read, backpressure and
//            mid-read reset cases are hand-written sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fios_host_loader;

    localparam int S      = 8;
    localparam int W      = 17;
    localparam int RD_LAT = 2;
    localparam int AW     = 5;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic [W-1:0]  in_data = '0;
    logic          out_ready = 1'b0;
    logic          done = 1'b0;
    logic          in_ready, out_valid, out_last;
    logic [W-1:0]  out_data;
    logic          bram_en, bram_we;
    logic [AW-1:0] bram_addr;
    logic [W-1:0]  bram_din;
    logic [W-1:0]  bram_s1 = '0;
    logic [W-1:0]  bram_dout = '0;
    logic          top_reset, top_start, busy;

    int checks = 0;
    int errors = 0;

    fios_host_loader #(.S(S), .W(W), .RD_LAT(RD_LAT)) dut (
        .clock_i     (clk),
        .reset_i     (rst_n),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .in_data_i   (in_data),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .out_data_o  (out_data),
        .out_last_o  (out_last),
        .BRAM_en_o   (bram_en),
        .BRAM_we_o   (bram_we),
        .BRAM_addr_o (bram_addr),
        .BRAM_din_o  (bram_din),
        .BRAM_dout_i (bram_dout),
        .top_reset_o (top_reset),
        .top_start_o (top_start),
        .top_done_i  (done),
        .busy_o      (busy)
    );

    always #5 clk = ~clk;

    // Two-cycle read BRAM model: every location reads back as 0x0A0 + addr
    always @(posedge clk) begin
        if (bram_en && !bram_we) begin
            bram_s1 <= W'(17'h0A0) + W'(bram_addr);
        end
        bram_dout <= bram_s1;
    end

    typedef struct {
        logic          vld;
        logic [W-1:0]  data;
        logic          done;
        logic          rdy;
        logic          en;
        logic          we;
        logic [AW-1:0] addr;
        logic [W-1:0]  din;
        logic          start;
        logic          treset;
        logic          busy;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Per-cycle expectations for one load: 25 writes (optionally with a
    // bubble every other cycle), the START cycle, then a few WAIT cycles
    // with in_valid held high. A done pulse is injected during LOAD.
    task automatic build_load(input bit gaps);
        int   w   = 0;
        int   cyc = 0;
        vec_t v;
        tbl.delete();
        while (w < 3 * S + 1) begin
            v.vld    = gaps ? (cyc % 2 == 0) : 1'b1;
            v.done   = (cyc == 3 || cyc == 4);
            v.rdy    = 1'b1;
            v.start  = 1'b0;
            v.treset = (cyc == 0);
            v.busy   = (cyc != 0);
            v.we     = v.vld;
            v.en     = v.vld;
            v.data   = v.vld ? W'(17'h100 + w) : W'(17'h1FFFF);
            v.addr   = AW'(w);
            v.din    = W'(17'h100 + w);
            tbl.push_back(v);
            if (v.vld) w++;
            cyc++;
        end
        for (int i = 0; i < 4; i++) begin
            v.vld    = 1'b1;
            v.data   = W'(17'h1BEEF);
            v.done   = 1'b0;
            v.rdy    = 1'b0;
            v.en     = 1'b0;
            v.we     = 1'b0;
            v.addr   = '0;
            v.din    = '0;
            v.start  = (i == 0);
            v.treset = 1'b0;
            v.busy   = 1'b1;
            tbl.push_back(v);
        end
    endtask

    task automatic apply_load(input bit gaps);
        build_load(gaps);
        foreach (tbl[i]) begin
            in_valid = tbl[i].vld;
            in_data  = tbl[i].data;
            done     = tbl[i].done;
            @(negedge clk);
            chk($sformatf("ld[%0d].rdy", i),    in_ready,  tbl[i].rdy);
            chk($sformatf("ld[%0d].en", i),     bram_en,   tbl[i].en);
            chk($sformatf("ld[%0d].we", i),     bram_we,   tbl[i].we);
            chk($sformatf("ld[%0d].start", i),  top_start, tbl[i].start);
            chk($sformatf("ld[%0d].treset", i), top_reset, tbl[i].treset);
            chk($sformatf("ld[%0d].busy", i),   busy,      tbl[i].busy);
            if (tbl[i].en) begin
                chk($sformatf("ld[%0d].addr", i), bram_addr, tbl[i].addr);
                chk($sformatf("ld[%0d].din", i),  bram_din,  tbl[i].din);
            end
            tick;
        end
        done     = 1'b0;
        in_valid = 1'b0;
    endtask

    // Remaining WAIT cycles (controller busy) with in_valid toggling, then
    // done is raised for the single edge that moves the loader to READ.
    task automatic wait_phase;
        int bad = 0;
        for (int c = 0; c < 46; c++) begin
            in_valid = (c % 2 == 1);
            in_data  = W'(17'h1ABCD);
            @(negedge clk);
            if (in_ready || bram_en || top_start || top_reset || !busy) bad++;
            tick;
        end
        chk("wait_quiet", bad, 0);
        in_valid = 1'b0;
        done     = 1'b1;
        tick;
        done = 1'b0;
    endtask

    // Collects result words starting in the first READ cycle. hold > 0 keeps
    // out_ready low for that many cycles; stop_after >= 0 leaves the loop
    // once that many words have been popped.
    task automatic read_job(input int hold, input int stop_after);
        int idx = 0, issued = 0, first = -1, lastc = -1, cyc = 0, unstable = 0;
        out_ready = (hold == 0);
        while (idx < S && cyc < 300 && !(stop_after >= 0 && idx == stop_after)) begin
            @(negedge clk);
            if (cyc < hold) begin
                if (bram_en && !bram_we) issued++;
                if (out_valid && out_data !== W'(17'h0A0)) unstable++;
                if (cyc == hold - 1) begin
                    chk("bp_issued", issued, 4);
                    chk("bp_valid", out_valid, 1);
                    chk("bp_data", out_data, 17'h0A0);
                    chk("bp_stable", unstable, 0);
                end
            end
            if (out_valid && out_ready) begin
                chk($sformatf("rd[%0d].data", idx), out_data, 17'h0A0 + idx);
                chk($sformatf("rd[%0d].last", idx), out_last, (idx == S - 1));
                if (first < 0) first = cyc;
                lastc = cyc;
                idx++;
            end
            tick;
            cyc++;
            if (cyc == hold) out_ready = 1'b1;
        end
        if (stop_after < 0) begin
            chk("rd_count", idx, S);
            chk("rd_burst", lastc - first, S - 1);
            @(negedge clk);
            chk("end_treset", top_reset, 1);
            chk("end_busy", busy, 0);
            chk("end_valid", out_valid, 0);
            chk("end_rdy", in_ready, 1);
            tick;
        end else begin
            chk("rd_partial", idx, stop_after);
        end
    endtask

    initial begin
        // Reset with in_valid high: nothing may be accepted or written
        rst_n    = 1'b0;
        in_valid = 1'b1;
        in_data  = W'(17'h1FFFF);
        tick;
        tick;
        @(negedge clk);
        chk("rst_treset", top_reset, 1);
        chk("rst_rdy", in_ready, 0);
        chk("rst_en", bram_en, 0);
        chk("rst_busy", busy, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_start", top_start, 0);
        tick;
        rst_n    = 1'b1;
        in_valid = 1'b0;

        // Job 1: gap-free load, free-flowing read
        apply_load(1'b0);
        wait_phase();
        read_job(0, -1);

        // Job 2: bubbled load, 20 cycles of backpressure on the output
        apply_load(1'b1);
        wait_phase();
        read_job(20, -1);

        // Job 3: reset after three words have been popped
        apply_load(1'b0);
        wait_phase();
        read_job(0, 3);
        rst_n = 1'b0;
        @(negedge clk);
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_treset", top_reset, 1);
        tick;
        rst_n     = 1'b1;
        out_ready = 1'b0;
        @(negedge clk);
        chk("post_rst_busy", busy, 0);
        chk("post_rst_valid", out_valid, 0);
        chk("post_rst_rdy", in_ready, 1);
        chk("post_rst_treset", top_reset, 1);
        chk("post_rst_en", bram_en, 0);
        tick;

        // Job 4: fresh job after the abort
        apply_load(1'b0);
        wait_phase();
        read_job(0, -1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fios_host_loader.md
Name: fios_host_loader

Overview:
- Host-side front end for the FIOS cascade top controller.
- Receives a stream of operand words, writes them into the shared operand/result BRAM, pulses the controller start, and waits for controller done.
- Then reads the s-word result back out of the BRAM and presents it as a flow-controlled output stream.
- Owns the BRAM write/read port facing the host; the controller owns the other port.

Parameters:
- s, 8, number of limbs per operand.
- W, 17, BRAM word width in bits.
- RD_LAT, 2, BRAM read latency in cycles (en/addr to dout valid).
- AW, $clog2(4*s), BRAM address width (derived, not overridable).

Ports:
- clock_i  in  1  clock.
- reset_i  in  1  synchronous reset, active-low.
- in_valid_i  in  1  operand word valid.
- in_ready_o  out  1  operand word accepted when in_valid_i & in_ready_o.
- in_data_i  in  W  operand word.
- out_valid_o  out  1  result word valid.
- out_ready_i  in  1  result sink ready.
- out_data_o  out  W  result word.
- out_last_o  out  1  marks result word s-1.
- BRAM_en_o  out  1  BRAM port enable.
- BRAM_we_o  out  1  BRAM write enable.
- BRAM_addr_o  out  AW  BRAM address.
- BRAM_din_o  out  W  BRAM write data.
- BRAM_dout_i  in  W  BRAM read data.
- top_reset_o  out  1  active-high reset to the controller.
- top_start_o  out  1  one-cycle start pulse to the controller.
- top_done_i  in  1  controller done level.
- busy_o  out  1  high in every state except IDLE.

Behaviour:
- Reset (reset_i=0 at an edge): state IDLE, counters 0, read FIFO flushed, in-flight reads discarded. All outputs 0 except top_reset_o=1. Applies mid-operation from any state.
- Memory map: addr 0 holds p'_0. Addrs 1..s hold p. Addrs s+1..2s hold a. Addrs 2s+1..3s hold b. Result words 0..s-1 are at addrs 0..s-1. Words are least-significant limb first.
- IDLE: top_reset_o=1, in_ready_o=1. The first in_valid_i handshake writes the word to addr 0 (BRAM_en_o=BRAM_we_o=1, same cycle, combinational from the handshake) and moves to LOAD with the word counter at 1.
- LOAD: top_reset_o=0, in_ready_o=1. Each handshake writes to addr=counter and increments the counter. The handshake at counter 3s moves to START. No handshake means no BRAM access.
- START: in_ready_o=0, top_start_o=1 for exactly this one cycle, then WAIT.
- WAIT: no BRAM access. Stays in WAIT until top_done_i=1 is sampled, then READ with issue counter 0.
- READ:
  - A read is issued (BRAM_en_o=1, BRAM_we_o=0, addr=issue counter) when issue counter < s and (FIFO occupancy + reads in flight) < 4.
  - Read data is captured RD_LAT cycles after issue into a 4-entry FIFO.
  - out_valid_o = FIFO non-empty. out_data_o/out_last_o come from the FIFO head. out_last_o=1 only on result index s-1.
  - A pop happens on out_valid_o & out_ready_i. A simultaneous push and pop on a full or empty FIFO is legal.
  - The pop of the last word moves to IDLE, so the controller is reset again by top_reset_o.
- Holds under backpressure: out_ready_i held 0 leaves out_data_o stable and lets no more than 4 reads be outstanding; no word is lost or duplicated.
- The next job may begin in the cycle after returning to IDLE.
- top_done_i is ignored outside WAIT. in_valid_i is ignored while in_ready_o=0.
- Counters wrap-free: the word counter never exceeds 3s and the issue counter never exceeds s.

Test Plan:
- s=8, stream words 0x100..0x118 with no gaps -> 25 writes at addrs 0..24 with matching data, top_start_o high for exactly 1 cycle the cycle after the addr-24 write, top_reset_o low from the first LOAD cycle.
- in_valid_i toggling 1/0 every cycle during load -> writes occur only on handshake cycles, addresses stay contiguous 0..24.
- BRAM model returns 0x0A0+addr, top_done_i asserted 50 cycles after start, out_ready_i=1 -> out_data_o sequence 0x0A0..0x0A7 on 8 consecutive cycles once the pipe fills, out_last_o on 0x0A7 only, then IDLE with top_reset_o=1.
- out_ready_i=0 for 20 cycles during READ -> exactly 4 reads issued, out_data_o stable at 0x0A0. On release, all 8 words arrive in order with no duplicates.
- Reset pulled low during READ after 3 words popped -> next cycle state IDLE, out_valid_o=0, FIFO empty. A fresh job then completes correctly.
- top_done_i pulsed during LOAD, and in_valid_i asserted during WAIT -> both ignored; in_ready_o=0 in WAIT.
